// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and helpers for the LED dot-matrix source arbiter and the mode
// control block.
//   state_e     : arbiter FSM states (IDLE / BLANK / ACTIVE)
//   DEF_*       : default bus widths for the matrix and status LED bank
//   lsb_index() : lowest-set-bit priority encoder over a MAX_SRC-wide vector
// -----------------------------------------------------------------------------
package matrix_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   localparam int DEF_ROWS  = 5;
   localparam int DEF_COLS  = 7;
   localparam int DEF_LED_W = 8;

   // Widest request vector the helper encoder accepts.
   localparam int MAX_SRC   = 32;
   localparam int MAX_IDX_W = $clog2(MAX_SRC);

   // Index of the lowest set bit; 0 when no bit is set (callers qualify the
   // result with their own "any" flag). Scanning from the top down lets the
   // lowest set bit overwrite every higher one.
   function automatic logic [MAX_IDX_W-1:0] lsb_index(input logic [MAX_SRC-1:0] vec);
      logic [MAX_IDX_W-1:0] res;
      res = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (vec[i]) begin
            res = MAX_IDX_W'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Lowest-set-bit priority encoder with an "any request" flag. Bit 0 has the
// highest priority. Shared with the mode control block.
// Ports:
//   req  in  N      request vector
//   idx  out IDX_W  index of the lowest set bit (0 when req is all zero)
//   any  out 1      at least one request bit is set
// -----------------------------------------------------------------------------
module prio_enc
   import matrix_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [MAX_SRC-1:0] req_ext;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      idx            = IDX_W'(lsb_index(req_ext));
      any            = |req;
   end

endmodule

// File: rtl/matrix_src_arbiter.sv
// -----------------------------------------------------------------------------
// matrix_src_arbiter
// Selects one of NUM_SRC display sources onto the LED dot-matrix row/column
// bus and the status LED bank. Every change of selected source passes through
// a BLANK interval of BLANK_CYCLES counts with the matrix driven dark, which
// keeps the old and new images from ghosting into each other. All pin outputs
// are registered.
// Ports:
//   CLOCK_50    in   1              system clock
//   rst_n       in   1              asynchronous active-low reset
//   src_en      in   NUM_SRC        per-source enable, bit 0 highest priority
//   src_row     in   NUM_SRC*ROWS   packed row buses, source i at [i*ROWS +: ROWS]
//   src_col     in   NUM_SRC*COLS   packed column buses, source i at [i*COLS +: COLS]
//   src_led     in   NUM_SRC        per-source overlay bit for the LED MSB
//   led_in      in   LED_W          status LEDs, passed through with 1-cycle latency
//   row         out  ROWS           registered row drive
//   column      out  COLS           registered column drive
//   leds        out  LED_W          registered status LEDs
//   active_idx  out  IDX_W          source currently owning the bus
//   active_vld  out  1              FSM is in ACTIVE
//   switching   out  1              FSM is in BLANK
//
// Handshake: none. src_en is a level-sensitive request; the selected source
// owns the bus only while its enable stays the highest-priority one set.
// -----------------------------------------------------------------------------
module matrix_src_arbiter
   import matrix_pkg::*;
#(
   parameter int NUM_SRC      = 4,
   parameter int ROWS         = DEF_ROWS,
   parameter int COLS         = DEF_COLS,
   parameter int LED_W        = DEF_LED_W,
   parameter int BLANK_CYCLES = 1000,
   localparam int IDX_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                    CLOCK_50,
   input  logic                    rst_n,
   input  logic [NUM_SRC-1:0]      src_en,
   input  logic [NUM_SRC*ROWS-1:0] src_row,
   input  logic [NUM_SRC*COLS-1:0] src_col,
   input  logic [NUM_SRC-1:0]      src_led,
   input  logic [LED_W-1:0]        led_in,
   output logic [ROWS-1:0]         row,
   output logic [COLS-1:0]         column,
   output logic [LED_W-1:0]        leds,
   output logic [IDX_W-1:0]        active_idx,
   output logic                    active_vld,
   output logic                    switching
);

   localparam int                CNT_W    = $clog2(BLANK_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLANK_CYCLES - 1);

   // Combinational selection
   logic [IDX_W-1:0] sel_idx;
   logic             sel_any;

   prio_enc #(
      .N     (NUM_SRC),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req (src_en),
      .idx (sel_idx),
      .any (sel_any)
   );

   // State
   state_e           state_q,    state_d;
   logic [IDX_W-1:0] cur_idx_q,  cur_idx_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [IDX_W-1:0] prev_sel_q, prev_sel_d;

   // Output registers
   logic [ROWS-1:0]  row_q,        row_d;
   logic [COLS-1:0]  column_q,     column_d;
   logic [LED_W-1:0] leds_q,       leds_d;
   logic [IDX_W-1:0] active_idx_q, active_idx_d;
   logic             active_vld_q, active_vld_d;
   logic             switching_q,  switching_d;

   logic             drive_en;

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cur_idx_d  = cur_idx_q;
      cnt_d      = cnt_q;
      prev_sel_d = sel_idx;

      case (state_q)
         IDLE: begin
            if (sel_any) begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         end
         BLANK: begin
            if (!sel_any) begin
               state_d = IDLE;
            end else if (sel_idx != prev_sel_q) begin
               // Selection moved while blanking: the dark interval restarts
               // so the new source always gets a full blank before it shows.
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ACTIVE;
               cur_idx_d = sel_idx;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (!sel_any) begin
               state_d = IDLE;
            end else if (sel_idx != cur_idx_q) begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic. drive_en also checks the live selection so that the edge
   // which first sees a new source already loads zeros, instead of letting
   // one more cycle of the old source through.
   always_comb begin
      drive_en = (state_q == ACTIVE) && sel_any && (sel_idx == cur_idx_q);

      row_d    = '0;
      column_d = '0;
      if (drive_en) begin
         row_d    = src_row[cur_idx_q*ROWS +: ROWS];
         column_d = src_col[cur_idx_q*COLS +: COLS];
      end

      leds_d          = led_in;
      leds_d[LED_W-1] = led_in[LED_W-1] | (drive_en & src_led[cur_idx_q]);

      active_idx_d = cur_idx_q;
      active_vld_d = (state_d == ACTIVE);
      switching_d  = (state_d == BLANK);
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cur_idx_q    <= '0;
         cnt_q        <= '0;
         prev_sel_q   <= '0;
         row_q        <= '0;
         column_q     <= '0;
         leds_q       <= '0;
         active_idx_q <= '0;
         active_vld_q <= 1'b0;
         switching_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_idx_q    <= cur_idx_d;
         cnt_q        <= cnt_d;
         prev_sel_q   <= prev_sel_d;
         row_q        <= row_d;
         column_q     <= column_d;
         leds_q       <= leds_d;
         active_idx_q <= active_idx_d;
         active_vld_q <= active_vld_d;
         switching_q  <= switching_d;
      end
   end

   assign row        = row_q;
   assign column     = column_q;
   assign leds       = leds_q;
   assign active_idx = active_idx_q;
   assign active_vld = active_vld_q;
   assign switching  = switching_q;

endmodule
